// File: rtl/button_debounce.sv
// Four-channel push-button conditioner: 2-flop synchroniser, polarity normalisation
// and an independent debounce FSM per channel producing a clean level plus press/release strobes.
module button_debounce #(
  parameter int P_WIDTH      = 4,
  parameter int P_DEB_CNT    = 1_000_000,
  parameter bit P_ACTIVE_LOW = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [P_WIDTH-1:0] i_btn,
  output logic [P_WIDTH-1:0] o_btn,
  output logic [P_WIDTH-1:0] o_press,
  output logic [P_WIDTH-1:0] o_release
);

  localparam int CNT_W = $clog2(P_DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PCHK,
    HELD,
    RCHK
  } state_t;

  logic [P_WIDTH-1:0] sync_p0;
  logic [P_WIDTH-1:0] sync_p1;

  // Stage p0/p1: metastability guard; sync_p1 is 1 = pressed regardless of pin polarity
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_btn ^ {P_WIDTH{P_ACTIVE_LOW}};
      sync_p1 <= sync_p0;
    end
  end

  for (genvar ch = 0; ch < P_WIDTH; ch++) begin : g_chan
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             btn_q;
    logic             press_q;
    logic             release_q;
    logic             btn_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             sync;

    assign sync = sync_p1[ch];

    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state_nxt = PCHK;
            cnt_nxt   = '0;
          end
        end
        PCHK: begin
          if (!sync) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state_nxt = RCHK;
            cnt_nxt   = '0;
          end
        end
        RCHK: begin
          if (sync) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      // Level follows the accepted state, so it toggles on the same edge as the strobe
      btn_nxt = (state_nxt == HELD) || (state_nxt == RCHK);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        btn_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        btn_q     <= btn_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign o_btn[ch]     = btn_q;
    assign o_press[ch]   = press_q;
    assign o_release[ch] = release_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce; a stable-run-length reference model
// feeds a scoreboard queue that a negedge monitor drains against the DUT outputs.
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int W   = 4;
  localparam int DEB = 8;
  localparam bit AL  = 1'b1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] btn_pin;
  logic [W-1:0] btn;
  logic [W-1:0] press;
  logic [W-1:0] release_s;

  int checks   = 0;
  int failures = 0;

  button_debounce #(
    .P_WIDTH     (W),
    .P_DEB_CNT   (DEB),
    .P_ACTIVE_LOW(AL)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_btn    (btn_pin),
    .o_btn    (btn),
    .o_press  (press),
    .o_release(release_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel's level flips once the synchronised input (two edges behind
  // the pin) has disagreed with it on DEB+1 consecutive edges; any agreement restarts the run.
  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   m_s1, m_s2, m_lvl;
  int             m_run[W];

  always @(posedge clk) begin
    logic [W-1:0] p, r;
    p = '0;
    r = '0;
    if (!rst_n) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DEB + 1) begin
            m_lvl[c] = m_s2[c];
            if (m_s2[c]) p[c] = 1'b1;
            else         r[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_pin ^ {W{AL}};
    end
    exp_q.push_back({m_lvl, p, r});
  end

  always @(negedge clk) begin
    logic [3*W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({btn, press, release_s} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual btn=%b press=%b rel=%b required btn=%b press=%b rel=%b",
                 $time, btn, press, release_s, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Starting from the edge that first samples the new pin value, count edges until btn[ch]==lvl.
  task automatic edges_to(input int ch, input logic lvl, output int k);
    @(posedge clk);
    #1;
    k = 0;
    while (btn[ch] !== lvl && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    int k;
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [W-1:0] raw;
    rst_n   = 1'b0;
    btn_pin = 4'b1111;
    #23;
    check("reset_btn", btn, 0);
    check("reset_press", press, 0);
    check("reset_release", release_s, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(50);
    check("idle_btn", btn, 0);

    // Clean press on channel 0
    btn_pin[0] = 1'b0;
    edges_to(0, 1'b1, k);
    check("press0_latency", k, 10);
    check("press0_strobe", press, 4'b0001);
    check("press0_others", btn, 4'b0001);
    @(posedge clk);
    #1;
    check("press0_one_cycle", press, 0);

    // Bounce on channel 1
    cycles(1);
    btn_pin[1] = 1'b0;
    cycles(5);
    btn_pin[1] = 1'b1;
    cycles(2);
    btn_pin[1] = 1'b0;
    edges_to(1, 1'b1, k);
    check("bounce1_latency", k, 10);
    check("bounce1_strobe", press, 4'b0010);

    // Release with glitch on channel 2
    cycles(1);
    btn_pin[2] = 1'b0;
    cycles(14);
    check("ch2_held", btn[2], 1);
    btn_pin[2] = 1'b1;
    cycles(7);
    btn_pin[2] = 1'b0;
    cycles(1);
    btn_pin[2] = 1'b1;
    edges_to(2, 1'b0, k);
    check("release2_latency", k, 10);
    check("release2_strobe", release_s, 4'b0100);

    // Reset in the middle of a press check on channel 3
    cycles(1);
    btn_pin[3] = 1'b0;
    cycles(6);
    rst_n = 1'b0;
    #1;
    check("midreset_btn", btn, 0);
    check("midreset_press", press, 0);
    check("midreset_release", release_s, 0);
    cycles(3);
    rst_n = 1'b1;
    edges_to(3, 1'b1, k);
    check("postreset3_latency", k, 10);
    check("postreset_btn", btn, 4'b1011);
    check("postreset_press", press, 4'b1011);

    // All channels at once
    cycles(1);
    btn_pin = 4'b1111;
    cycles(20);
    check("all_released", btn, 0);
    btn_pin = 4'b0000;
    edges_to(0, 1'b1, k);
    check("all_latency", k, 10);
    check("all_btn", btn, 4'b1111);
    check("all_press", press, 4'b1111);

    // Random phase: mostly slow toggling with occasional chatter bursts and resets
    cycles(1);
    raw = btn_pin;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < W; c++) begin
        if ((i / 300) % 3 == 2) begin
          if ($urandom_range(0, 2) == 0) raw[c] = ~raw[c];
        end else if ($urandom_range(0, 15) == 0) begin
          raw[c] = ~raw[c];
        end
      end
      btn_pin = raw;
      if ($urandom_range(0, 700) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", {btn, press, release_s}, 0);
        cycles(2);
        rst_n = 1'b1;
      end else begin
        cycles(1);
      end
    end
    btn_pin = 4'b1111;
    cycles(30);
    check("final_btn", btn, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
